// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer definitions: geometry, slot encoding and the
// pixel address helper also used by the drawing logic.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 19;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } slot_t;

  // row*640 + col without a multiplier: 640 = 512 + 128
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] row,
                                                   input logic [9:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 9) + (r << 7) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering game-logic pixel writes until a
// blanking slot is free. Full, empty and level are registered.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // occupancy after this edge, used to register full/empty directly
  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LW'(1);
    end else if (do_pop && !do_push) begin
      level_nxt = level - LW'(1);
    end
  end

  // entry storage; validity is tracked by the pointers, so no reset here
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers and status flags
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads always win, buffered game
// writes are committed only in slots where the read strobe is idle.
//
//   state  | meaning
//   S_IDLE | no RAM access this slot (idle, off-screen read, bad write)
//   S_RD   | RAM read for the VGA scan-out
//   S_WR   | RAM write of the FIFO head entry
module vram_port_arbiter #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int DATA_W     = vga_pkg::DATA_W,
  parameter int ADDR_W     = vga_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          vga_clk,
  input  logic                          clrn,
  input  logic                          vga_rdn,
  input  logic [8:0]                    vga_row,
  input  logic [9:0]                    vga_col,
  output logic [DATA_W-1:0]             vga_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [8:0]                    wr_row,
  input  logic [9:0]                    wr_col,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [DATA_W-1:0]             ram_din,
  input  logic [DATA_W-1:0]             ram_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_oob
);

  import vga_pkg::*;

  localparam int ENTRY_W = 9 + 10 + DATA_W;

  slot_t               state_q;
  slot_t               state_d;
  logic [ENTRY_W-1:0]  head;
  logic [8:0]          head_row;
  logic [9:0]          head_col;
  logic [DATA_W-1:0]   head_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                ready_en;
  logic                push;
  logic                pop;
  logic                rd_ok;
  logic                head_ok;
  logic                rd_issue;
  logic                rd_valid;
  logic                oob_pop;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   din_d;
  logic [1:0]          issue_q;
  logic [1:0]          valid_q;

  assign {head_row, head_col, head_data} = head;

  assign rd_ok   = (vga_row < 9'(V_ACTIVE)) && (vga_col < 10'(H_ACTIVE));
  assign head_ok = (head_row < 9'(V_ACTIVE)) && (head_col < 10'(H_ACTIVE));

  // ready_en keeps the writer stalled until the first edge out of reset
  assign wr_ready = ready_en && !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign ram_we   = (state_q == S_WR);

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk   (vga_clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .din   ({wr_row, wr_col, wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // slot decision: read strobe first, otherwise drain one buffered write
  always_comb begin
    state_d  = S_IDLE;
    addr_d   = ram_addr;
    din_d    = ram_din;
    pop      = 1'b0;
    rd_issue = 1'b0;
    rd_valid = 1'b0;
    oob_pop  = 1'b0;
    if (!vga_rdn) begin
      rd_issue = 1'b1;
      if (rd_ok) begin
        state_d  = S_RD;
        rd_valid = 1'b1;
        addr_d   = ADDR_W'(pixel_addr(vga_row, vga_col));
      end
    end else if (!fifo_empty) begin
      pop = 1'b1;
      if (head_ok) begin
        state_d = S_WR;
        addr_d  = ADDR_W'(pixel_addr(head_row, head_col));
        din_d   = head_data;
      end else begin
        oob_pop = 1'b1;
      end
    end
  end

  // slot register and RAM-side outputs
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      ram_addr <= '0;
      ram_din  <= '0;
      ready_en <= 1'b0;
      err_oob  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ram_addr <= addr_d;
      ram_din  <= din_d;
      ready_en <= 1'b1;
      if (oob_pop) err_oob <= 1'b1;
    end
  end

  // read-return pipeline: issue/valid tags line up with ram_dout two edges later
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      issue_q  <= '0;
      valid_q  <= '0;
      vga_data <= '0;
    end else begin
      issue_q <= {issue_q[0], rd_issue};
      valid_q <= {valid_q[0], rd_valid};
      if (issue_q[1]) begin
        vga_data <= valid_q[1] ? ram_dout : '0;
      end
    end
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares one single-port 640×480×12-bit frame-buffer RAM between the VGA scan-out reader and the game-logic pixel writer. The VGA read port has absolute priority whenever the controller asserts its active-low read strobe. Game writes are buffered in a small FIFO and committed only in idle (blanking) slots. The block sits between the VGA controller (`rdn`/`row_addr`/`col_addr`/`d_in`), the sprite/scene drawing logic, and the frame-buffer RAM.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible columns; also the row stride.
- `V_ACTIVE`, 480: visible rows.
- `DATA_W`, 12: pixel width (4:4:4 RGB).
- `ADDR_W`, 19: RAM word address width.
- `FIFO_DEPTH`, 4: write-buffer entries; must be a power of two.

Ports:
- `vga_clk`  in  1  pixel clock; the only clock.
- `clrn`  in  1  reset; synchronous, active-low.
- `vga_rdn`  in  1  read strobe from the VGA controller; 0 = pixel read this cycle.
- `vga_row`  in  9  scan row.
- `vga_col`  in  10  scan column.
- `vga_data`  out  12  pixel returned to the VGA controller's `d_in`; registered.
- `wr_valid`  in  1  writer has a pixel.
- `wr_ready`  out  1  FIFO can accept; registered.
- `wr_row`  in  9  target row.
- `wr_col`  in  10  target column.
- `wr_data`  in  12  pixel value.
- `ram_addr`  out  19  RAM address; registered.
- `ram_we`  out  1  RAM write enable; registered.
- `ram_din`  out  12  RAM write data; registered.
- `ram_dout`  in  12  RAM read data; 1-cycle synchronous read latency.
- `fifo_level`  out  3  current FIFO occupancy, 0..4.
- `err_oob`  out  1  sticky flag: an out-of-range write was accepted.

## Operation
- Address: `row*H_ACTIVE + col`, computed as `(row<<9)+(row<<7)+col`; 19-bit unsigned, no wrap.
- Slot FSM, one slot per cycle, registered state `S_IDLE`/`S_RD`/`S_WR`:
  - `vga_rdn`=0 and coordinates in range → `S_RD`: `ram_we`=0, `ram_addr`=read address.
  - `vga_rdn`=0 and coordinates out of range → `S_IDLE`; the returned pixel is forced to 0, and the RAM is not accessed.
  - `vga_rdn`=1 and FIFO non-empty → `S_WR`: pop the head entry and drive `ram_we`=1 with its address/data.
  - otherwise → `S_IDLE`: `ram_we`=0, `ram_addr` holds its last value.
- Reads always win. A write pending during active video waits, with no timeout, until `vga_rdn` rises.
- Write handshake: a push occurs on a cycle where `wr_valid`&&`wr_ready`.
  - `wr_ready` = registered not-full. It does not anticipate a same-cycle pop.
  - There is no bypass: a pushed entry is poppable no earlier than the next cycle.
- Out-of-range writes (`wr_row`≥480 or `wr_col`≥640) are accepted, then discarded at pop time. They consume a slot with `ram_we`=0 and set `err_oob`.
- Writes are committed in FIFO order. Last write to the same address wins.

## Timing
- Reset values: `vga_data`=0, `ram_addr`=0, `ram_we`=0, `ram_din`=0, `wr_ready`=0 (rises to 1 on the first cycle after `clrn` deasserts), `fifo_level`=0, `err_oob`=0, FSM=`S_IDLE`.
- Reset mid-operation: FIFO contents are discarded, and any in-flight read returns 0.
- Read latency: `vga_rdn`=0 sampled at edge N → `ram_addr` valid after N → `ram_dout` valid after N+1 → `vga_data` updates at edge N+2.
  - Fixed latency of 3 edges, with no bubbles.
  - The VGA controller issues its addresses 3 pixels ahead to compensate.
- A valid-tag pipeline (2 stages) selects between `ram_dout` and 0 at the output stage.
- Write commit: a pop at edge N drives `ram_we`=1 for the cycle after N.
- Best-case accept-to-RAM latency is 2 edges.
- `fifo_level` updates on the edge of each push/pop. Simultaneous push and pop leave it unchanged.

## Structure
- Shared package `vga_pkg` holds:
  - `H_ACTIVE`, `V_ACTIVE`, `DATA_W`, `ADDR_W`;
  - the `slot_t` enum;
  - the `pixel_addr(row,col)` function, shared with the drawing logic.
- One sub-module, `vram_wr_fifo`:
  - synchronous FIFO of {row, col, data}, 31 bits wide;
  - outputs: registered full/empty and level.
- The arbiter FSM, address computation and read-return pipeline live in the top level.

## Test plan
- Reset: hold `clrn`=0 for 4 cycles with `wr_valid`=1 → all outputs 0 and no push; `wr_ready`=1 one cycle after release.
- Blanking write: `vga_rdn`=1, push (row 10, col 20, data 12'hF00) → `ram_we`=1 with `ram_addr`=6420 and `ram_din`=12'hF00 exactly 2 edges after accept.
- Read latency: preload address 641 with 12'h0A5; `vga_rdn`=0 at (1,1) → `vga_data`=12'h0A5 at edge N+2. A streaming 640-pixel row returns in order with no bubbles.
- Priority: push 3 writes while `vga_rdn`=0 for 100 cycles → `ram_we` stays 0 and `fifo_level`=3. All three commit in order on the first 3 cycles after `vga_rdn` rises.
- Backpressure: `vga_rdn`=0 and 6 pushes attempted → 4 accepted and `wr_ready`=0. A simultaneous push/pop at full is refused.
- Out of range: push (row 480, col 0) → no RAM write and `err_oob`=1, sticky until reset. A read at col 700 returns 0.
